fsm_prog_loader: RTL

//  Sequences programming of the programmable FSM Controller. Accepts the next-state table as bytes over a valid/ready stream.

---
 rtl/fsm_loader_pkg.sv | 28 ++
 rtl/fsm_loader_crc8.sv | 26 ++
 rtl/fsm_prog_loader.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/fsm_loader_pkg.sv
// Shared types and constants for the FSM Controller program loader.
// The CRC helpers are used only when FSM_LOADER_CRC_EN is defined.
package fsm_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_BYTE,
    SHIFT,
    CHECK,
    FINISH
  } loader_state_e;

  localparam logic [7:0] CRC8_POLY = 8'h07;
  localparam logic [7:0] CRC8_INIT = 8'h00;

  // Each state has one next-state entry for in=0 and one for in=1.
  function automatic int table_bits(input int state_count);
    return 2 * state_count * $clog2(state_count);
  endfunction

  // Advance an MSB-first CRC-8 by one message bit.
  function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic bit_in);
    logic feedback;
    feedback = crc[7] ^ bit_in;
    return {crc[6:0], 1'b0} ^ (feedback ? CRC8_POLY : 8'h00);
  endfunction

endpackage

// File: rtl/fsm_loader_crc8.sv
// Bit-serial CRC-8 over the bits shifted into the FSM Controller.
// The module exists only when FSM_LOADER_CRC_EN is defined.
`ifdef FSM_LOADER_CRC_EN
module fsm_loader_crc8
  import fsm_loader_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       clear,
  input  logic       bit_valid,
  input  logic       bit_in,
  output logic [7:0] crc
);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      crc <= CRC8_INIT;
    end else if (clear) begin
      crc <= CRC8_INIT;
    end else if (bit_valid) begin
      crc <= crc8_step(crc, bit_in);
    end
  end

endmodule
`endif

// File: rtl/fsm_prog_loader.sv
// Streams the next-state table into the FSM Controller MSB-first over its shared data pin.
// Define FSM_LOADER_CRC_EN to add a CRC-8 check byte after the table.
module fsm_prog_loader
  import fsm_loader_pkg::*;
#(
  parameter int STATE_COUNT = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic       abort,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       run_in,
  output logic       prog_enable,
  output logic       fsm_data,
  output logic       busy,
  output logic       done,
  output logic       crc_ok
);

  localparam int STATE_WIDTH = $clog2(STATE_COUNT);
  localparam int TABLE_BITS  = 2 * STATE_COUNT * STATE_WIDTH;
  localparam int BYTE_COUNT  = (table_bits(STATE_COUNT) + 7) / 8;
  localparam int BYTE_W      = (BYTE_COUNT > 1) ? $clog2(BYTE_COUNT) : 1;

  // The final byte carries only the remaining table bits; its low bits are dropped.
  localparam logic [3:0]        LAST_NBITS = 4'(TABLE_BITS - 8 * (BYTE_COUNT - 1));
  localparam logic [BYTE_W-1:0] LAST_BYTE  = BYTE_W'(BYTE_COUNT - 1);

  loader_state_e     state;
  logic [7:0]        shreg;
  logic [3:0]        bit_cnt;
  logic [BYTE_W-1:0] byte_cnt;

  assign fsm_data = prog_enable ? shreg[7] : run_in;

`ifdef FSM_LOADER_CRC_EN
  logic [7:0] crc;
  logic       crc_clear;

  assign crc_clear = (state == IDLE) && start && !abort;

  fsm_loader_crc8 u_crc (
    .clock     (clock),
    .reset     (reset),
    .clear     (crc_clear),
    .bit_valid (prog_enable),
    .bit_in    (shreg[7]),
    .crc       (crc)
  );
`endif

  // NOTE: every register here is reset asynchronously and updated with non-blocking
  // assignments so all outputs change together on the clock edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      shreg       <= '0;
      bit_cnt     <= '0;
      byte_cnt    <= '0;
      in_ready    <= 1'b0;
      prog_enable <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      crc_ok      <= 1'b1;
    end else begin
      done <= 1'b0;
      if (abort && state != IDLE) begin
        state       <= IDLE;
        in_ready    <= 1'b0;
        prog_enable <= 1'b0;
        busy        <= 1'b0;
        crc_ok      <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start && !abort) begin
              state    <= WAIT_BYTE;
              busy     <= 1'b1;
              in_ready <= 1'b1;
              byte_cnt <= '0;
            end
          end

          WAIT_BYTE: begin
            if (in_valid) begin
              shreg       <= in_data;
              bit_cnt     <= (byte_cnt == LAST_BYTE) ? LAST_NBITS : 4'd8;
              in_ready    <= 1'b0;
              prog_enable <= 1'b1;
              state       <= SHIFT;
            end
          end

          SHIFT: begin
            shreg   <= {shreg[6:0], 1'b0};
            bit_cnt <= bit_cnt - 4'd1;
            if (bit_cnt == 4'd1) begin
              prog_enable <= 1'b0;
              if (byte_cnt != LAST_BYTE) begin
                byte_cnt <= byte_cnt + 1'b1;
                in_ready <= 1'b1;
                state    <= WAIT_BYTE;
              end else begin
`ifdef FSM_LOADER_CRC_EN
                in_ready <= 1'b1;
                state    <= CHECK;
`else
                done     <= 1'b1;
                busy     <= 1'b0;
                crc_ok   <= 1'b1;
                state    <= FINISH;
`endif
              end
            end
          end

          CHECK: begin
`ifdef FSM_LOADER_CRC_EN
            // The CRC register already includes the last table bit here.
            if (in_valid) begin
              crc_ok   <= (in_data == crc);
              in_ready <= 1'b0;
              done     <= 1'b1;
              busy     <= 1'b0;
              state    <= FINISH;
            end
`else
            state <= IDLE;
`endif
          end

          FINISH: state <= IDLE;

          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
